// File: rtl/bcd_display_driver.sv
// Two-digit multiplexed 7-segment driver for a 0..15 value split into tens/ones,
// with a cross-check of the upstream over-nine flag against the captured value.
module bcd_display_driver #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] v,
    input  logic       z,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       err
);

    localparam int              CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_t;

    logic [CW-1:0] r_cnt;
    slot_t         r_slot;
    logic          r_tens;
    logic [3:0]    r_ones;
    logic          r_err;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_wrap;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg_dec;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_an_nxt;

    assign w_wrap  = (r_cnt == CNT_MAX);
    assign w_digit = (r_slot == SLOT_TENS) ? {3'b000, r_tens} : r_ones;

    // Segment patterns are g..a, active low; codes above 9 show a lone dash.
    always_comb begin
        w_seg_dec = 7'b0111111;
        case (w_digit)
            4'd0:    w_seg_dec = 7'b1000000;
            4'd1:    w_seg_dec = 7'b1111001;
            4'd2:    w_seg_dec = 7'b0100100;
            4'd3:    w_seg_dec = 7'b0110000;
            4'd4:    w_seg_dec = 7'b0011001;
            4'd5:    w_seg_dec = 7'b0010010;
            4'd6:    w_seg_dec = 7'b0000010;
            4'd7:    w_seg_dec = 7'b1111000;
            4'd8:    w_seg_dec = 7'b0000000;
            4'd9:    w_seg_dec = 7'b0010000;
            default: w_seg_dec = 7'b0111111;
        endcase
    end

    always_comb begin
        w_an_nxt  = 4'b1110;
        w_seg_nxt = w_seg_dec;
        if (r_slot == SLOT_TENS) begin
            if (BLANK_LEADING && !r_tens) begin
                w_an_nxt  = 4'b1111;
                w_seg_nxt = 7'b1111111;
            end else begin
                w_an_nxt  = 4'b1101;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_slot <= SLOT_ONES;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_slot <= (r_slot == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Ones wraps mod 16 when z is asserted for a value below ten; err records it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tens <= 1'b0;
            r_ones <= '0;
            r_err  <= 1'b0;
        end else if (load) begin
            r_tens <= z;
            r_ones <= z ? (v - 4'd10) : v;
            r_err  <= z ^ (v > 4'd9);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= '1;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = 1'b1;
    assign err = r_err;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: two instances (leading blank on/off)
// share stimulus; expected displays are queued per edge and checked on negedges.
module tb_bcd_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] v;
    logic       z;

    logic [6:0] seg_b1, seg_b0;
    logic [3:0] an_b1, an_b0;
    logic       dp_b1, dp_b0, err_b1, err_b0;

    bcd_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut_b1 (
        .clk(clk), .rst(rst), .load(load), .v(v), .z(z),
        .seg(seg_b1), .an(an_b1), .dp(dp_b1), .err(err_b1)
    );

    bcd_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut_b0 (
        .clk(clk), .rst(rst), .load(load), .v(v), .z(z),
        .seg(seg_b0), .an(an_b0), .dp(dp_b0), .err(err_b0)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_ZERO  = 7'b1000000;
    localparam logic [6:0] S_ONE   = 7'b1111001;

    typedef struct {
        int unsigned at;
        logic [6:0]  seg1;
        logic [3:0]  an1;
        logic [6:0]  seg0;
        logic [3:0]  an0;
        logic        err;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Edges since reset release; output at edge k shows slot ((k-1)/4)%2.
    int unsigned cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            if (e.at != cyc) begin
                check({e.nm, "/stale_at"}, cyc, e.at);
            end else begin
                check({e.nm, "/seg_b1"}, 32'(seg_b1), 32'(e.seg1));
                check({e.nm, "/an_b1"},  32'(an_b1),  32'(e.an1));
                check({e.nm, "/seg_b0"}, 32'(seg_b0), 32'(e.seg0));
                check({e.nm, "/an_b0"},  32'(an_b0),  32'(e.an0));
                check({e.nm, "/err_b1"}, 32'(err_b1), 32'(e.err));
                check({e.nm, "/err_b0"}, 32'(err_b0), 32'(e.err));
                check({e.nm, "/dp_b1"},  32'(dp_b1),  32'd1);
                check({e.nm, "/dp_b0"},  32'(dp_b0),  32'd1);
            end
        end
    end

    function automatic logic slot_at(input int unsigned k);
        return 1'(((k - 1) / 4) % 2);
    endfunction

    function automatic int unsigned next_slot(input int unsigned after, input logic s);
        for (int unsigned k = after + 1; k < after + 20; k++)
            if (slot_at(k) == s) return k;
        return after + 1;
    endfunction

    task automatic push_entry(input int unsigned at, input logic is_tens, input logic [6:0] os,
                              input logic tv, input logic ee, input string nm);
        exp_t e;
        e.at = at; e.err = ee; e.nm = nm;
        if (!is_tens) begin
            e.seg1 = os; e.an1 = 4'b1110; e.seg0 = os; e.an0 = 4'b1110;
        end else begin
            e.seg0 = tv ? S_ONE : S_ZERO;
            e.an0  = 4'b1101;
            e.seg1 = tv ? S_ONE : S_BLANK;
            e.an1  = tv ? 4'b1101 : 4'b1111;
        end
        q.push_back(e);
    endtask

    task automatic push_digits(input int unsigned l, input logic [6:0] os, input logic tv,
                               input logic ee, input string nm, output int unsigned last);
        int unsigned k1, k2;
        k1 = next_slot(l, 1'b0);
        k2 = next_slot(l, 1'b1);
        if (k1 < k2) begin
            push_entry(k1, 1'b0, os, tv, ee, {nm, "/ones"});
            push_entry(k2, 1'b1, os, tv, ee, {nm, "/tens"});
            last = k2;
        end else begin
            push_entry(k2, 1'b1, os, tv, ee, {nm, "/tens"});
            push_entry(k1, 1'b0, os, tv, ee, {nm, "/ones"});
            last = k1;
        end
    endtask

    task automatic wait_until(input int unsigned k, input string nm);
        int unsigned n = 0;
        while (cyc < k && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (cyc < k) check({nm, "/timeout"}, cyc, k);
    endtask

    task automatic drain(input string nm);
        int unsigned n = 0;
        while (q.size() > 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) check({nm, "/drain_timeout"}, q.size(), 0);
    endtask

    // Called at a negedge: the load is sampled on the following rising edge.
    task automatic do_load(input logic [3:0] vv, input logic zz, input logic [6:0] os,
                           input logic tv, input logic ee, input string nm);
        int unsigned last;
        push_digits(cyc + 1, os, tv, ee, nm, last);
        v = vv; z = zz; load = 1'b1;
        @(negedge clk);
        load = 1'b0; v = 4'hA; z = ~zz;
        wait_until(last, nm);
    endtask

    task automatic check_reset(input string nm);
        check({nm, "/seg_b1"}, 32'(seg_b1), 32'(S_BLANK));
        check({nm, "/an_b1"},  32'(an_b1),  32'b1111);
        check({nm, "/seg_b0"}, 32'(seg_b0), 32'(S_BLANK));
        check({nm, "/an_b0"},  32'(an_b0),  32'b1111);
        check({nm, "/err_b1"}, 32'(err_b1), 32'd0);
        check({nm, "/err_b0"}, 32'(err_b0), 32'd0);
        check({nm, "/dp_b1"},  32'(dp_b1),  32'd1);
    endtask

    initial begin
        int unsigned last;
        int unsigned l;
        int unsigned n;
        rst = 1'b1; load = 1'b0; v = 4'd0; z = 1'b0;
        #12;
        check_reset("reset_init");
        @(negedge clk);
        rst = 1'b0;
        push_digits(0, S_ZERO, 1'b0, 1'b0, "post_reset", last);
        wait_until(last, "post_reset");

        do_load(4'd13, 1'b1, 7'b0110000, 1'b1, 1'b0, "v13z1");
        do_load(4'd7,  1'b0, 7'b1111000, 1'b0, 1'b0, "v7z0");
        do_load(4'd11, 1'b0, 7'b0111111, 1'b0, 1'b1, "v11z0_err");
        do_load(4'd3,  1'b1, 7'b0010000, 1'b1, 1'b1, "v3z1_err");
        do_load(4'd5,  1'b0, 7'b0010010, 1'b0, 1'b0, "v5z0");
        do_load(4'd9,  1'b0, 7'b0010000, 1'b0, 1'b0, "v9z0");
        do_load(4'd10, 1'b1, 7'b1000000, 1'b1, 1'b0, "v10z1");
        do_load(4'd15, 1'b1, 7'b0010010, 1'b1, 1'b0, "v15z1");

        // Load on an edge where the slot wraps back to ones.
        n = 0;
        while (cyc % 8 != 7 && n < 16) begin
            @(negedge clk);
            n++;
        end
        l = cyc + 1;
        push_entry(l + 1, 1'b0, 7'b0011001, 1'b0, 1'b0, "wrap_load");
        v = 4'd4; z = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_until(l + 1, "wrap_load");

        // Hold "12" for 20 edges with load low.
        l = cyc + 1;
        for (int unsigned k = l + 1; k <= l + 20; k++)
            push_entry(k, slot_at(k), 7'b0100100, 1'b1, 1'b0, "hold12");
        v = 4'd12; z = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0; v = 4'd6; z = 1'b0;
        wait_until(l + 20, "hold12");

        do_load(4'd11, 1'b0, 7'b0111111, 1'b0, 1'b1, "pre_reset_err");
        drain("pre_reset_err");

        // Asynchronous reset while the tens slot is displayed.
        n = 0;
        while (!(cyc >= 1 && slot_at(cyc) == 1'b1 && ((cyc - 1) % 4) == 1) && n < 16) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1 check_reset("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        push_digits(0, S_ZERO, 1'b0, 1'b0, "resume", last);
        wait_until(last, "resume");
        drain("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
